// File: rtl/prog_loader.sv
// Purpose: front-panel program loader; writes switch bytes into the 256x8 program memory while the CPU is held.
// Latency: key edge to action is 2 sync + DEBOUNCE_CYCLES debounce + 1 event cycle; MemWrite is a 1-cycle strobe.
// Backpressure: none; the memory always accepts. Events that arrive while a write is in flight are dropped.
//
// Ports:
//   CLOCK_50  system clock, all state on its rising edge
//   reset     synchronous active-high reset
//   SW_data   byte to write, or new address value
//   key_write raw write request (async, bouncy)
//   key_addr  raw request to load the address pointer from SW_data
//   key_run   raw run/stop toggle
//   MemWrite  one-cycle write strobe per accepted write
//   ADDR      memory address (the pointer register)
//   Data_in   memory write data, valid while MemWrite=1
//   cpu_hold  1 holds the processor clock-enable and PC
//   words     writes since reset, saturating at 256
//   running   1 in RUN state
module prog_loader #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 20
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] SW_data,
   input  logic       key_write,
   input  logic       key_addr,
   input  logic       key_run,
   output logic       MemWrite,
   output logic [7:0] ADDR,
   output logic [7:0] Data_in,
   output logic       cpu_hold,
   output logic [8:0] words,
   output logic       running
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      WRITE = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // bit 0 = write, bit 1 = addr, bit 2 = run
   logic [2:0]       key_raw;
   logic [2:0]       sync1;
   logic [2:0]       sync2;
   logic [2:0]       db;
   logic [2:0]       db_prev;
   logic [CNT_W-1:0] cnt [3];
   logic [2:0]       ev;

   state_t state;
   state_t state_nxt;

   logic [7:0] addr_q;
   logic [7:0] data_q;
   logic [8:0] words_q;

   assign key_raw = {key_run, key_addr, key_write};

   // Synchronizer + debounce: db only follows s after s has differed from
   // db for DEBOUNCE_CYCLES consecutive cycles; any return to db restarts.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1   <= '0;
         sync2   <= '0;
         db      <= '0;
         db_prev <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         sync1   <= key_raw;
         sync2   <= sync1;
         db_prev <= db;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Rising-edge events only; releases never trigger anything.
   assign ev = db & ~db_prev;

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= LOAD;
      else       state <= state_nxt;
   end

   // Next-state logic; priority write > addr > run, losers are dropped.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD: begin
            if (ev[0])                state_nxt = WRITE;
            else if (!ev[1] && ev[2]) state_nxt = RUN;
         end
         WRITE:   state_nxt = LOAD;
         RUN:     if (ev[2]) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // Datapath: pointer, write data, saturating word count.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         addr_q  <= '0;
         data_q  <= '0;
         words_q <= '0;
      end else begin
         if (state == LOAD) begin
            if (ev[0])      data_q <= SW_data;
            else if (ev[1]) addr_q <= SW_data;
         end
         if (state == WRITE) begin
            addr_q <= addr_q + 8'd1;
            if (words_q != 9'd256) words_q <= words_q + 9'd1;
         end
      end
   end

   // Outputs decoded from state; WRITE lasts exactly one cycle, so the
   // strobe is one cycle and can never coincide with RUN.
   always_comb begin
      MemWrite = (state == WRITE);
      cpu_hold = (state != RUN);
      running  = (state == RUN);
      ADDR     = addr_q;
      Data_in  = data_q;
      words    = words_q;
   end

endmodule

// File: tb/tb_prog_loader.sv
// Purpose: directed bench for prog_loader: vector table plus hand sequences for latency, saturation and reset-in-write.
// Latency: expects the write strobe 7 edges after the first sampled key edge with DEBOUNCE_CYCLES=4.
// Backpressure: n/a; all outputs are sampled 1 time unit after the rising edge.
module tb_prog_loader;

   logic       CLOCK_50;
   logic       reset;
   logic [7:0] SW_data;
   logic       key_write;
   logic       key_addr;
   logic       key_run;
   logic       MemWrite;
   logic [7:0] ADDR;
   logic [7:0] Data_in;
   logic       cpu_hold;
   logic [8:0] words;
   logic       running;

   int n_vec = 0;
   int n_err = 0;
   int hold_viol = 0;

   prog_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .SW_data  (SW_data),
      .key_write(key_write),
      .key_addr (key_addr),
      .key_run  (key_run),
      .MemWrite (MemWrite),
      .ADDR     (ADDR),
      .Data_in  (Data_in),
      .cpu_hold (cpu_hold),
      .words    (words),
      .running  (running)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      bit       rst;
      bit [2:0] keys;   // {run, addr, write}
      int       len;
      bit [7:0] sw;
      int       nwr;
      bit [7:0] waddr;
      bit [7:0] wdata;
      bit [7:0] addr;
      int       wcnt;
      bit       hold;
   } vec_t;

   vec_t tbl [11];

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      key_write = 1'b0;
      key_addr  = 1'b0;
      key_run   = 1'b0;
      reset     = 1'b1;
      step();
      step();
      reset     = 1'b0;
   endtask

   // Holds the selected keys for len cycles, then idles long enough for the
   // debounced levels to fall again. Reports strobes seen and the first one.
   task automatic press(input bit [2:0] keys, input int len, input bit [7:0] sw,
                        output int nwr, output int first,
                        output bit [7:0] wa, output bit [7:0] wd);
      nwr   = 0;
      first = 0;
      wa    = 8'h00;
      wd    = 8'h00;
      SW_data = sw;
      {key_run, key_addr, key_write} = keys;
      for (int s = 1; s <= len + 14; s++) begin
         step();
         if (MemWrite) begin
            nwr++;
            if (!cpu_hold) hold_viol++;
            if (first == 0) begin
               first = s;
               wa    = ADDR;
               wd    = Data_in;
            end
         end
         if (s == len) {key_run, key_addr, key_write} = 3'b000;
      end
   endtask

   initial begin
      int nwr, first, total;
      bit [7:0] wa, wd;

      reset = 1'b0; SW_data = 8'h00;
      key_write = 1'b0; key_addr = 1'b0; key_run = 1'b0;

      // Reset state
      do_reset();
      check("rst_memwrite", MemWrite, 0);
      check("rst_addr",     ADDR,     0);
      check("rst_data",     Data_in,  0);
      check("rst_hold",     cpu_hold, 1);
      check("rst_words",    words,    0);
      check("rst_running",  running,  0);

      // Long press: exactly one strobe, at step 7 (cycle after edge 6)
      press(3'b001, 20, 8'hA5, nwr, first, wa, wd);
      check("long_nwr",   nwr,   1);
      check("long_lat",   first, 7);
      check("long_waddr", wa,    8'h00);
      check("long_wdata", wd,    8'hA5);
      check("long_addr",  ADDR,  8'h01);
      check("long_words", words, 1);

      //         rst keys    len sw     nwr waddr  wdata  addr   wcnt hold
      tbl[0]  = '{1, 3'b001, 3, 8'h33, 0, 8'h00, 8'h00, 8'h00, 0, 1}; // glitch
      tbl[1]  = '{0, 3'b001, 5, 8'h44, 1, 8'h00, 8'h44, 8'h01, 1, 1};
      tbl[2]  = '{1, 3'b010, 6, 8'hFF, 0, 8'h00, 8'h00, 8'hFF, 0, 1}; // addr load
      tbl[3]  = '{0, 3'b001, 6, 8'h11, 1, 8'hFF, 8'h11, 8'h00, 1, 1}; // wraps
      tbl[4]  = '{0, 3'b001, 6, 8'h22, 1, 8'h00, 8'h22, 8'h01, 2, 1};
      tbl[5]  = '{0, 3'b101, 6, 8'h77, 1, 8'h01, 8'h77, 8'h02, 3, 1}; // write beats run
      tbl[6]  = '{0, 3'b100, 6, 8'h00, 0, 8'h00, 8'h00, 8'h02, 3, 0}; // enter RUN
      tbl[7]  = '{0, 3'b001, 6, 8'h55, 0, 8'h00, 8'h00, 8'h02, 3, 0}; // write ignored
      tbl[8]  = '{0, 3'b010, 6, 8'h80, 0, 8'h00, 8'h00, 8'h02, 3, 0}; // addr ignored
      tbl[9]  = '{0, 3'b100, 6, 8'h00, 0, 8'h00, 8'h00, 8'h02, 3, 1}; // back to LOAD
      tbl[10] = '{0, 3'b001, 4, 8'h66, 1, 8'h02, 8'h66, 8'h03, 4, 1}; // shortest press

      for (int v = 0; v < 11; v++) begin
         if (tbl[v].rst) do_reset();
         press(tbl[v].keys, tbl[v].len, tbl[v].sw, nwr, first, wa, wd);
         check($sformatf("v%0d_nwr", v), nwr, tbl[v].nwr);
         if (tbl[v].nwr != 0) begin
            check($sformatf("v%0d_lat", v),   first, 7);
            check($sformatf("v%0d_waddr", v), wa,    tbl[v].waddr);
            check($sformatf("v%0d_wdata", v), wd,    tbl[v].wdata);
         end
         check($sformatf("v%0d_addr", v),    ADDR,     tbl[v].addr);
         check($sformatf("v%0d_words", v),   words,    tbl[v].wcnt);
         check($sformatf("v%0d_hold", v),    cpu_hold, tbl[v].hold);
         check($sformatf("v%0d_running", v), running,  !tbl[v].hold);
      end

      // Saturation: 257 presses, count pins at 256, pointer wraps to 01
      do_reset();
      total = 0;
      for (int p = 1; p <= 257; p++) begin
         press(3'b001, 5, p[7:0], nwr, first, wa, wd);
         total += nwr;
         if (p == 256) begin
            check("sat_words_256", words, 256);
            check("sat_addr_256",  ADDR,  8'h00);
         end
      end
      check("sat_total", total, 257);
      check("sat_words", words, 256);
      check("sat_addr",  ADDR,  8'h01);

      // Reset asserted during the write cycle, key kept held throughout
      do_reset();
      SW_data   = 8'h5A;
      key_write = 1'b1;
      first = 0;
      for (int s = 1; s <= 20 && first == 0; s++) begin
         step();
         if (MemWrite) first = s;
      end
      check("rw_first_lat", first, 7);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rw_memwrite", MemWrite, 0);
      check("rw_addr",     ADDR,     0);
      check("rw_words",    words,    0);
      check("rw_hold",     cpu_hold, 1);
      first = 0;
      wa    = 8'hEE;
      for (int s = 1; s <= 20; s++) begin
         step();
         if (MemWrite && first == 0) begin
            first = s;
            wa    = ADDR;
         end
      end
      key_write = 1'b0;
      check("rw_relat",  first, 7);
      check("rw_waddr",  wa,    8'h00);
      check("rw_words1", words, 1);
      check("rw_addr1",  ADDR,  8'h01);

      check("no_write_in_run", hold_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
